// File: rtl/change_dispenser.sv
// change_dispenser: splits a cent amount into dollar/quarter/dime eject pulses.
// Each coin is a PULSE_CYC-cycle high pulse followed by GAP_CYC low cycles.
// Optional feature macro: CHANGE_DISPENSER_COIN_COUNT_EN adds cumulative
// per-coin eject counters; without it cnt_* are tied to zero.
module change_dispenser #(
    parameter int PULSE_CYC = 4,
    parameter int GAP_CYC   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] change_in,
    output logic        busy,
    output logic        coin_dollar,
    output logic        coin_quarter,
    output logic        coin_dime,
    output logic        done,
    output logic [3:0]  residue,
    output logic [15:0] cnt_dollar,
    output logic [15:0] cnt_quarter,
    output logic [15:0] cnt_dime
);

    typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_t;

    localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYC - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_CYC - 1);

    state_t      state_q;
    logic [15:0] rem_q;
    logic [15:0] rem_d;
    logic [7:0]  phase_q;
    logic        busy_q, done_q;
    logic        dol_q, qtr_q, dim_q;
    logic [3:0]  residue_q;
    logic        pick_dol, pick_qtr, pick_dim, pick_any;

    // Coin choice by priority; quarters are only used on odd-five amounts
    // below 50 so that e.g. 40 becomes four dimes rather than stranding 15.
    always_comb begin
        pick_dol = (rem_q >= 16'd100);
        pick_qtr = !pick_dol && ((rem_q >= 16'd50) ||
                   ((rem_q >= 16'd25) && ((rem_q % 16'd10) == 16'd5)));
        pick_dim = !pick_dol && !pick_qtr && (rem_q >= 16'd10);
        pick_any = pick_dol | pick_qtr | pick_dim;
        rem_d    = rem_q;
        if (pick_dol)      rem_d = rem_q - 16'd100;
        else if (pick_qtr) rem_d = rem_q - 16'd25;
        else if (pick_dim) rem_d = rem_q - 16'd10;
    end

    // Main sequencer; all outputs are registered so a coin rises on the
    // cycle after SELECT and drops on the cycle after the last PULSE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            phase_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dol_q     <= 1'b0;
            qtr_q     <= 1'b0;
            dim_q     <= 1'b0;
            residue_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rem_q   <= change_in;
                        busy_q  <= 1'b1;
                        state_q <= SELECT;
                    end
                end
                SELECT: begin
                    phase_q <= '0;
                    if (pick_any) begin
                        rem_q   <= rem_d;
                        dol_q   <= pick_dol;
                        qtr_q   <= pick_qtr;
                        dim_q   <= pick_dim;
                        state_q <= PULSE;
                    end else begin
                        done_q    <= 1'b1;
                        residue_q <= rem_q[3:0];
                        state_q   <= DONE;
                    end
                end
                PULSE: begin
                    if (phase_q == PULSE_LAST) begin
                        phase_q <= '0;
                        dol_q   <= 1'b0;
                        qtr_q   <= 1'b0;
                        dim_q   <= 1'b0;
                        state_q <= GAP;
                    end else begin
                        phase_q <= phase_q + 8'd1;
                    end
                end
                GAP: begin
                    if (phase_q == GAP_LAST) begin
                        phase_q <= '0;
                        state_q <= SELECT;
                    end else begin
                        phase_q <= phase_q + 8'd1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign coin_dollar  = dol_q;
    assign coin_quarter = qtr_q;
    assign coin_dime    = dim_q;
    assign residue      = residue_q;

`ifdef CHANGE_DISPENSER_COIN_COUNT_EN
    logic [15:0] cnt_dol_q, cnt_qtr_q, cnt_dim_q;
    logic        first_pulse;

    assign first_pulse = (state_q == PULSE) && (phase_q == 8'd0);

    // Count each coin once, on the first cycle of its pulse; wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_dol_q <= '0;
            cnt_qtr_q <= '0;
            cnt_dim_q <= '0;
        end else if (first_pulse) begin
            if (dol_q) cnt_dol_q <= cnt_dol_q + 16'd1;
            if (qtr_q) cnt_qtr_q <= cnt_qtr_q + 16'd1;
            if (dim_q) cnt_dim_q <= cnt_dim_q + 16'd1;
        end
    end

    assign cnt_dollar  = cnt_dol_q;
    assign cnt_quarter = cnt_qtr_q;
    assign cnt_dime    = cnt_dim_q;
`else
    assign cnt_dollar  = '0;
    assign cnt_quarter = '0;
    assign cnt_dime    = '0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: a coin/residue scoreboard filled from a small
// reference model at each start and drained by a negedge monitor, plus
// directed cycle-exact traces for latency/busy/done timing.
module tb_change_dispenser;

    localparam int P = 4;
    localparam int G = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] change_in;
    logic        busy, coin_dollar, coin_quarter, coin_dime, done;
    logic [3:0]  residue;
    logic [15:0] cnt_dollar, cnt_quarter, cnt_dime;

    int total = 0;
    int bad   = 0;

    logic [2:0] exp_coin[$];
    logic [3:0] exp_res[$];

    change_dispenser #(.PULSE_CYC(P), .GAP_CYC(G)) dut (
        .clk(clk), .rst(rst), .start(start), .change_in(change_in),
        .busy(busy), .coin_dollar(coin_dollar), .coin_quarter(coin_quarter),
        .coin_dime(coin_dime), .done(done), .residue(residue),
        .cnt_dollar(cnt_dollar), .cnt_quarter(cnt_quarter), .cnt_dime(cnt_dime)
    );

    always #5 clk = ~clk;

    // Reference model: coin codes are {dollar,quarter,dime}.
    function automatic void push_model(input int amt);
        int r;
        r = amt;
        while (r >= 10) begin
            if (r >= 100) begin
                exp_coin.push_back(3'b100); r = r - 100;
            end else if (r >= 50 || (r >= 25 && (r % 10) == 5)) begin
                exp_coin.push_back(3'b010); r = r - 25;
            end else begin
                exp_coin.push_back(3'b001); r = r - 10;
            end
        end
        exp_res.push_back(4'(r));
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_v(input string tag, input logic [39:0] obs, input logic [39:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, obs, expv);
        end
    endtask

    // Monitor: coin order, pulse width, one-hot, residue at done.
    logic [2:0] cur_c;
    logic [2:0] prev_c = 3'b000;
    logic [2:0] pop_c;
    logic [3:0] pop_r;
    int         width = 0;

    always @(negedge clk) begin
        cur_c = {coin_dollar, coin_quarter, coin_dime};
        if (rst) begin
            prev_c = 3'b000;
            width  = 0;
        end else begin
            total++;
            assert ($countones(cur_c) <= 1) else begin
                bad++;
                $error("FAIL onehot got=%b exp=at_most_one", cur_c);
            end
            if (cur_c != 3'b000 && prev_c == 3'b000) begin
                total++;
                assert (exp_coin.size() !== 0) else begin
                    bad++;
                    $error("FAIL unexpected_coin got=%b exp=none", cur_c);
                end
                if (exp_coin.size() != 0) begin
                    pop_c = exp_coin.pop_front();
                    total++;
                    assert (cur_c === pop_c) else begin
                        bad++;
                        $error("FAIL coin_order got=%b exp=%b", cur_c, pop_c);
                    end
                end
                width = 1;
            end else if (cur_c != 3'b000) begin
                width++;
            end
            if (cur_c == 3'b000 && prev_c != 3'b000) begin
                total++;
                assert (width === P) else begin
                    bad++;
                    $error("FAIL pulse_width got=%0d exp=%0d", width, P);
                end
            end
            if (done) begin
                total++;
                assert (exp_res.size() !== 0) else begin
                    bad++;
                    $error("FAIL unexpected_done got=1 exp=0");
                end
                if (exp_res.size() != 0) begin
                    pop_r = exp_res.pop_front();
                    total++;
                    assert (residue === pop_r) else begin
                        bad++;
                        $error("FAIL residue got=%0d exp=%0d", residue, pop_r);
                    end
                end
                total++;
                assert (exp_coin.size() === 0) else begin
                    bad++;
                    $error("FAIL coins_left_at_done got=%0d exp=0", exp_coin.size());
                end
            end
            prev_c = cur_c;
        end
    end

    task automatic do_start(input int amt);
        @(posedge clk); #1;
        start = 1'b1; change_in = 16'(amt);
        push_model(amt);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int seen;
        seen = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
        chk(tag, seen, 1);
    endtask

    // Start in cycle 0 and record busy/done/dime/other-coin per cycle.
    task automatic trace(input int amt, input int n, output logic [39:0] b,
                         output logic [39:0] d, output logic [39:0] dm, output logic [39:0] o);
        b = '0; d = '0; dm = '0; o = '0;
        @(posedge clk); #1;
        start = 1'b1; change_in = 16'(amt);
        push_model(amt);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            b[k]  = busy;
            d[k]  = done;
            dm[k] = coin_dime;
            o[k]  = coin_dollar | coin_quarter;
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    logic [39:0] tb_b, tb_d, tb_dm, tb_o;
    logic [39:0] ex_b, ex_d, ex_dm;
    int          seen_dol;

    initial begin
        rst = 1'b1; start = 1'b0; change_in = '0;
        #1;
        chk("async_rst_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_coins", {coin_dollar, coin_quarter, coin_dime}, 0);
        chk("rst_residue", residue, 0);
        chk("rst_cnt", {cnt_dollar, cnt_quarter, cnt_dime}, 0);
        rst = 1'b0;

        // 30 cents: three dimes, exact timing
        trace(30, 34, tb_b, tb_d, tb_dm, tb_o);
        ex_b = '0; ex_d = '0; ex_dm = '0;
        for (int k = 1; k <= 29; k++) ex_b[k] = 1'b1;
        ex_d[29] = 1'b1;
        for (int k = 2; k <= 5; k++)   ex_dm[k] = 1'b1;
        for (int k = 11; k <= 14; k++) ex_dm[k] = 1'b1;
        for (int k = 20; k <= 23; k++) ex_dm[k] = 1'b1;
        chk_v("t30_busy", tb_b, ex_b);
        chk_v("t30_done", tb_d, ex_d);
        chk_v("t30_dime", tb_dm, ex_dm);
        chk_v("t30_other", tb_o, 40'd0);

        // zero cents: SELECT then DONE
        trace(0, 8, tb_b, tb_d, tb_dm, tb_o);
        chk_v("t0_busy", tb_b, 40'h6);
        chk_v("t0_done", tb_d, 40'h4);
        chk_v("t0_coins", tb_dm | tb_o, 40'd0);
        chk("t0_residue", residue, 0);

        // 160: dollar, quarter, quarter, dime
        do_start(160);
        wait_done("t160_done", 200);
        chk("t160_residue", residue, 0);

        // 15: one dime, residue 5
        do_start(15);
        wait_done("t15_done", 100);
        chk("t15_residue", residue, 5);

        // start while busy is ignored
        do_start(35);
        repeat (3) @(posedge clk);
        #1; start = 1'b1; change_in = 16'd100;
        @(posedge clk); #1; start = 1'b0;
        wait_done("t35_done", 100);
        chk("t35_residue", residue, 0);
        repeat (15) @(negedge clk);
        chk("t35_idle_busy", busy, 0);

        // reset in the middle of a dollar pulse
        do_start(100);
        seen_dol = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (coin_dollar) begin seen_dol = 1; break; end
        end
        chk("rstmid_dollar_seen", seen_dol, 1);
        rst = 1'b1;
        #1;
        chk("rstmid_coins", {coin_dollar, coin_quarter, coin_dime}, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_done", done, 0);
        exp_coin.delete();
        exp_res.delete();
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("rstmid_after_busy", busy, 0);
        chk("rstmid_after_coins", {coin_dollar, coin_quarter, coin_dime}, 0);

        // coin counters over two 125-cent dispenses
        do_start(125);
        wait_done("t125a_done", 100);
        do_start(125);
        wait_done("t125b_done", 100);
`ifdef CHANGE_DISPENSER_COIN_COUNT_EN
        chk("cnt_dollar", cnt_dollar, 2);
        chk("cnt_quarter", cnt_quarter, 2);
        chk("cnt_dime", cnt_dime, 0);
`else
        chk("cnt_dollar", cnt_dollar, 0);
        chk("cnt_quarter", cnt_quarter, 0);
        chk("cnt_dime", cnt_dime, 0);
`endif
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
